// File: rtl/axi_lite_pkg.sv
// Shared AXI4-Lite constants for the register slave and its storage bank.
package axi_lite_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam int AXI_DATA_W = 32;
  localparam int AXI_STRB_W = 4;

endpackage

// File: rtl/axi_lite_reg_bank.sv
// NUM_REGS x 32-bit register storage: one byte-enable write port, one
// combinational read port, and every register exported in parallel.
module axi_lite_reg_bank
  import axi_lite_pkg::*;
#(
  parameter int NUM_REGS = 8,
  localparam int IDX_W   = $clog2(NUM_REGS)
) (
  input  logic                           i_clk,
  input  logic                           i_srst,
  input  logic                           i_we,
  input  logic [IDX_W-1:0]               i_widx,
  input  logic [AXI_DATA_W-1:0]          i_wdata,
  input  logic [AXI_STRB_W-1:0]          i_wstrb,
  input  logic [IDX_W-1:0]               i_ridx,
  output logic [AXI_DATA_W-1:0]          o_rdata,
  output logic [AXI_DATA_W*NUM_REGS-1:0] o_reg_out
);

  logic [AXI_DATA_W*NUM_REGS-1:0] w_flat;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REGS; gi++) begin : g_reg
      logic [AXI_DATA_W-1:0] r_word;

      always_ff @(posedge i_clk) begin
        if (i_srst) begin
          r_word <= '0;
        end else if (i_we && (i_widx == IDX_W'(gi))) begin
          for (int b = 0; b < AXI_STRB_W; b++) begin
            if (i_wstrb[b]) begin
              r_word[8*b +: 8] <= i_wdata[8*b +: 8];
            end
          end
        end
      end

      assign w_flat[AXI_DATA_W*gi +: AXI_DATA_W] = r_word;
    end
  endgenerate

  assign o_rdata   = w_flat[AXI_DATA_W*i_ridx +: AXI_DATA_W];
  assign o_reg_out = w_flat;

endmodule

// File: rtl/axi_lite_slave_regs.sv
// AXI4-Lite slave front end: independent AW/W holding, single outstanding
// write and read, address decode; storage lives in axi_lite_reg_bank.
module axi_lite_slave_regs
  import axi_lite_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int NUM_REGS   = 8
) (
  input  logic                           ACLK,
  input  logic                           ARESET,
  input  logic [ADDR_WIDTH-1:0]          S_AXI_AWADDR,
  input  logic [2:0]                     S_AXI_AWPROT,
  input  logic                           S_AXI_AWVALID,
  output logic                           S_AXI_AWREADY,
  input  logic [AXI_DATA_W-1:0]          S_AXI_WDATA,
  input  logic [AXI_STRB_W-1:0]          S_AXI_WSTRB,
  input  logic                           S_AXI_WVALID,
  output logic                           S_AXI_WREADY,
  output logic [1:0]                     S_AXI_BRESP,
  output logic                           S_AXI_BVALID,
  input  logic                           S_AXI_BREADY,
  input  logic [ADDR_WIDTH-1:0]          S_AXI_ARADDR,
  input  logic [2:0]                     S_AXI_ARPROT,
  input  logic                           S_AXI_ARVALID,
  output logic                           S_AXI_ARREADY,
  output logic [AXI_DATA_W-1:0]          S_AXI_RDATA,
  output logic [1:0]                     S_AXI_RRESP,
  output logic                           S_AXI_RVALID,
  input  logic                           S_AXI_RREADY,
  output logic [AXI_DATA_W*NUM_REGS-1:0] REG_OUT
);

  localparam int IDX_W = $clog2(NUM_REGS);
  localparam logic [ADDR_WIDTH-3:0] REG_LIMIT = (ADDR_WIDTH-2)'(NUM_REGS);

  logic [ADDR_WIDTH-1:0] r_awaddr;
  logic [AXI_DATA_W-1:0] r_wdata;
  logic [AXI_STRB_W-1:0] r_wstrb;
  logic                  r_aw_held, r_w_held;
  logic                  r_awready, r_wready, r_bvalid, r_arready, r_rvalid;
  logic [1:0]            r_bresp, r_rresp;
  logic [AXI_DATA_W-1:0] r_rdata;

  logic                  w_aw_hs, w_w_hs, w_ar_hs, w_commit;
  logic                  w_aw_in_range, w_ar_in_range;
  logic                  w_aw_held_next, w_w_held_next, w_bvalid_next, w_rvalid_next;
  logic [1:0]            w_bresp_next, w_rresp_next;
  logic [AXI_DATA_W-1:0] w_rdata_next, w_bank_rdata;
  logic                  w_unused;

  assign w_aw_hs       = S_AXI_AWVALID && r_awready;
  assign w_w_hs        = S_AXI_WVALID && r_wready;
  assign w_ar_hs       = S_AXI_ARVALID && r_arready;
  assign w_commit      = r_aw_held && r_w_held;
  assign w_aw_in_range = r_awaddr[ADDR_WIDTH-1:2] < REG_LIMIT;
  assign w_ar_in_range = S_AXI_ARADDR[ADDR_WIDTH-1:2] < REG_LIMIT;

  always_comb begin
    w_aw_held_next = r_aw_held;
    w_w_held_next  = r_w_held;
    w_bvalid_next  = r_bvalid;
    w_bresp_next   = r_bresp;
    if (w_aw_hs) w_aw_held_next = 1'b1;
    if (w_w_hs)  w_w_held_next  = 1'b1;
    // Readies are low while both are held, so a commit never races a new handshake.
    if (w_commit) begin
      w_aw_held_next = 1'b0;
      w_w_held_next  = 1'b0;
      w_bvalid_next  = 1'b1;
      w_bresp_next   = w_aw_in_range ? RESP_OKAY : RESP_SLVERR;
    end else if (r_bvalid && S_AXI_BREADY) begin
      w_bvalid_next  = 1'b0;
    end
  end

  always_comb begin
    w_rvalid_next = r_rvalid;
    w_rdata_next  = r_rdata;
    w_rresp_next  = r_rresp;
    if (w_ar_hs) begin
      w_rvalid_next = 1'b1;
      w_rdata_next  = w_ar_in_range ? w_bank_rdata : '0;
      w_rresp_next  = w_ar_in_range ? RESP_OKAY : RESP_SLVERR;
    end else if (r_rvalid && S_AXI_RREADY) begin
      w_rvalid_next = 1'b0;
    end
  end

  // Readies are registered copies of the ready equations applied to next state.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      r_awaddr  <= '0;
      r_wdata   <= '0;
      r_wstrb   <= '0;
      r_aw_held <= 1'b0;
      r_w_held  <= 1'b0;
      r_awready <= 1'b0;
      r_wready  <= 1'b0;
      r_bvalid  <= 1'b0;
      r_bresp   <= RESP_OKAY;
      r_arready <= 1'b0;
      r_rvalid  <= 1'b0;
      r_rdata   <= '0;
      r_rresp   <= RESP_OKAY;
    end else begin
      if (w_aw_hs) r_awaddr <= S_AXI_AWADDR;
      if (w_w_hs) begin
        r_wdata <= S_AXI_WDATA;
        r_wstrb <= S_AXI_WSTRB;
      end
      r_aw_held <= w_aw_held_next;
      r_w_held  <= w_w_held_next;
      r_awready <= !w_aw_held_next && !w_bvalid_next;
      r_wready  <= !w_w_held_next && !w_bvalid_next;
      r_bvalid  <= w_bvalid_next;
      r_bresp   <= w_bresp_next;
      r_arready <= !w_rvalid_next;
      r_rvalid  <= w_rvalid_next;
      r_rdata   <= w_rdata_next;
      r_rresp   <= w_rresp_next;
    end
  end

  axi_lite_reg_bank #(
    .NUM_REGS (NUM_REGS)
  ) u_bank (
    .i_clk     (ACLK),
    .i_srst    (ARESET),
    .i_we      (w_commit && w_aw_in_range),
    .i_widx    (r_awaddr[2 +: IDX_W]),
    .i_wdata   (r_wdata),
    .i_wstrb   (r_wstrb),
    .i_ridx    (S_AXI_ARADDR[2 +: IDX_W]),
    .o_rdata   (w_bank_rdata),
    .o_reg_out (REG_OUT)
  );

  assign S_AXI_AWREADY = r_awready;
  assign S_AXI_WREADY  = r_wready;
  assign S_AXI_BVALID  = r_bvalid;
  assign S_AXI_BRESP   = r_bresp;
  assign S_AXI_ARREADY = r_arready;
  assign S_AXI_RVALID  = r_rvalid;
  assign S_AXI_RDATA   = r_rdata;
  assign S_AXI_RRESP   = r_rresp;

  assign w_unused = ^{S_AXI_AWPROT, S_AXI_ARPROT, r_awaddr[1:0], S_AXI_ARADDR[1:0]};

endmodule

// File: tb/tb_axi_lite_slave_regs.sv
// Self-checking bench for axi_lite_slave_regs: table of write/read vectors
// with a response scoreboard, plus hand-written multi-cycle sequences.
module tb_axi_lite_slave_regs;

  localparam int NR = 8;
  localparam int AW = 32;

  logic          ACLK = 1'b0;
  logic          ARESET = 1'b1;
  logic [AW-1:0] S_AXI_AWADDR = '0;
  logic [2:0]    S_AXI_AWPROT = '0;
  logic          S_AXI_AWVALID = 1'b0;
  logic          S_AXI_AWREADY;
  logic [31:0]   S_AXI_WDATA = '0;
  logic [3:0]    S_AXI_WSTRB = '0;
  logic          S_AXI_WVALID = 1'b0;
  logic          S_AXI_WREADY;
  logic [1:0]    S_AXI_BRESP;
  logic          S_AXI_BVALID;
  logic          S_AXI_BREADY = 1'b0;
  logic [AW-1:0] S_AXI_ARADDR = '0;
  logic [2:0]    S_AXI_ARPROT = '0;
  logic          S_AXI_ARVALID = 1'b0;
  logic          S_AXI_ARREADY;
  logic [31:0]   S_AXI_RDATA;
  logic [1:0]    S_AXI_RRESP;
  logic          S_AXI_RVALID;
  logic          S_AXI_RREADY = 1'b0;
  logic [32*NR-1:0] REG_OUT;

  axi_lite_slave_regs #(.ADDR_WIDTH(AW), .NUM_REGS(NR)) dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .S_AXI_AWADDR(S_AXI_AWADDR), .S_AXI_AWPROT(S_AXI_AWPROT),
    .S_AXI_AWVALID(S_AXI_AWVALID), .S_AXI_AWREADY(S_AXI_AWREADY),
    .S_AXI_WDATA(S_AXI_WDATA), .S_AXI_WSTRB(S_AXI_WSTRB),
    .S_AXI_WVALID(S_AXI_WVALID), .S_AXI_WREADY(S_AXI_WREADY),
    .S_AXI_BRESP(S_AXI_BRESP), .S_AXI_BVALID(S_AXI_BVALID), .S_AXI_BREADY(S_AXI_BREADY),
    .S_AXI_ARADDR(S_AXI_ARADDR), .S_AXI_ARPROT(S_AXI_ARPROT),
    .S_AXI_ARVALID(S_AXI_ARVALID), .S_AXI_ARREADY(S_AXI_ARREADY),
    .S_AXI_RDATA(S_AXI_RDATA), .S_AXI_RRESP(S_AXI_RRESP),
    .S_AXI_RVALID(S_AXI_RVALID), .S_AXI_RREADY(S_AXI_RREADY),
    .REG_OUT(REG_OUT)
  );

  always #5 ACLK = ~ACLK;

  typedef struct {
    logic        is_wr;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [1:0]  exp_resp;
    logic [31:0] exp_rdata;
  } vec_t;

  typedef struct {
    logic        is_wr;
    logic [1:0]  resp;
    logic [31:0] data;
  } sb_t;

  int checks = 0;
  int failures = 0;
  sb_t sb_q[$];
  logic [31:0] model [NR];
  vec_t vecs [15];

  task automatic tick();
    @(posedge ACLK);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
    end
  endtask

  task automatic chk_regs(input string name);
    logic [32*NR-1:0] exp;
    for (int i = 0; i < NR; i++) exp[32*i +: 32] = model[i];
    checks++;
    if (REG_OUT !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%064h required=0x%064h", name, REG_OUT, exp);
    end
  endtask

  task automatic model_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb);
    if (addr[31:2] < NR) begin
      for (int b = 0; b < 4; b++)
        if (strb[b]) model[addr[4:2]][8*b +: 8] = data[8*b +: 8];
    end
  endtask

  task automatic axi_write(input logic [31:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, input logic [1:0] exp_resp);
    sb_t e;
    int n;
    bit aw_d, w_d, aw_hs, w_hs;
    e.is_wr = 1'b1; e.resp = exp_resp; e.data = '0;
    sb_q.push_back(e);
    model_write(addr, data, strb);
    S_AXI_AWADDR = addr; S_AXI_AWVALID = 1'b1;
    S_AXI_WDATA = data; S_AXI_WSTRB = strb; S_AXI_WVALID = 1'b1;
    S_AXI_BREADY = 1'b1;
    n = 0; aw_d = 0; w_d = 0;
    while (!(aw_d && w_d) && n < 20) begin
      aw_hs = S_AXI_AWVALID && S_AXI_AWREADY;
      w_hs  = S_AXI_WVALID && S_AXI_WREADY;
      tick();
      if (aw_hs) begin aw_d = 1; S_AXI_AWVALID = 1'b0; end
      if (w_hs)  begin w_d = 1;  S_AXI_WVALID = 1'b0; end
      n++;
    end
    S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0;
    chk("wr_handshake", {30'd0, aw_d, w_d}, 32'd3);
    n = 0;
    while (!S_AXI_BVALID && n < 20) begin tick(); n++; end
    chk("wr_latency", n, 1);
    e = sb_q.pop_front();
    chk("bvalid", S_AXI_BVALID, 1);
    chk("bresp", S_AXI_BRESP, e.resp);
    $display("WR addr=0x%08h data=0x%08h strb=%b bresp=%b", addr, data, strb, S_AXI_BRESP);
    tick();
    chk("bvalid_drop", S_AXI_BVALID, 0);
    chk_regs("reg_out_after_wr");
  endtask

  task automatic axi_read(input logic [31:0] addr, input logic [31:0] exp_data, input logic [1:0] exp_resp);
    sb_t e;
    int n;
    bit hs, done;
    e.is_wr = 1'b0; e.resp = exp_resp; e.data = exp_data;
    sb_q.push_back(e);
    S_AXI_ARADDR = addr; S_AXI_ARVALID = 1'b1; S_AXI_RREADY = 1'b1;
    n = 0; done = 0;
    while (!done && n < 20) begin
      hs = S_AXI_ARVALID && S_AXI_ARREADY;
      tick();
      if (hs) done = 1;
      n++;
    end
    S_AXI_ARVALID = 1'b0;
    chk("rd_handshake", {31'd0, done}, 1);
    n = 0;
    while (!S_AXI_RVALID && n < 20) begin tick(); n++; end
    chk("rd_latency", n, 0);
    e = sb_q.pop_front();
    chk("rresp", S_AXI_RRESP, e.resp);
    chk("rdata", S_AXI_RDATA, e.data);
    $display("RD addr=0x%08h rdata=0x%08h rresp=%b", addr, S_AXI_RDATA, S_AXI_RRESP);
    tick();
    chk("rvalid_drop", S_AXI_RVALID, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] held_rdata;
    for (int i = 0; i < NR; i++) model[i] = '0;

    vecs[0]  = '{1'b1, 32'h0000_0004, 32'h1234_5678, 4'hF, 2'b00, 32'h0};
    vecs[1]  = '{1'b0, 32'h0000_0004, 32'h0,         4'h0, 2'b00, 32'h1234_5678};
    vecs[2]  = '{1'b1, 32'h0000_0008, 32'h1122_3344, 4'hF, 2'b00, 32'h0};
    vecs[3]  = '{1'b1, 32'h0000_0008, 32'hAABB_CCDD, 4'h5, 2'b00, 32'h0};
    vecs[4]  = '{1'b0, 32'h0000_0008, 32'h0,         4'h0, 2'b00, 32'h11BB_33DD};
    vecs[5]  = '{1'b1, 32'h0000_0040, 32'hDEAD_BEEF, 4'hF, 2'b10, 32'h0};
    vecs[6]  = '{1'b0, 32'h0000_0040, 32'h0,         4'h0, 2'b10, 32'h0};
    vecs[7]  = '{1'b1, 32'h0000_001F, 32'hCAFE_F00D, 4'h8, 2'b00, 32'h0};
    vecs[8]  = '{1'b0, 32'h0000_001C, 32'h0,         4'h0, 2'b00, 32'hCA00_0000};
    vecs[9]  = '{1'b1, 32'h0000_0000, 32'hFFFF_FFFF, 4'h3, 2'b00, 32'h0};
    vecs[10] = '{1'b0, 32'h0000_0003, 32'h0,         4'h0, 2'b00, 32'h0000_FFFF};
    vecs[11] = '{1'b0, 32'h0000_0020, 32'h0,         4'h0, 2'b10, 32'h0};
    vecs[12] = '{1'b0, 32'h0000_0004, 32'h0,         4'h0, 2'b00, 32'h1234_5678};
    vecs[13] = '{1'b1, 32'hFFFF_FFFC, 32'h0000_0001, 4'hF, 2'b10, 32'h0};
    vecs[14] = '{1'b0, 32'h0000_001C, 32'h0,         4'h0, 2'b00, 32'hCA00_0000};

    // Reset state
    repeat (3) tick();
    chk("rst_awready", S_AXI_AWREADY, 0);
    chk("rst_wready", S_AXI_WREADY, 0);
    chk("rst_arready", S_AXI_ARREADY, 0);
    chk("rst_bvalid", S_AXI_BVALID, 0);
    chk("rst_rvalid", S_AXI_RVALID, 0);
    chk("rst_rdata", S_AXI_RDATA, 0);
    chk_regs("rst_regs");
    ARESET = 1'b0;
    tick();
    chk("post_rst_awready", S_AXI_AWREADY, 1);
    chk("post_rst_wready", S_AXI_WREADY, 1);
    chk("post_rst_arready", S_AXI_ARREADY, 1);

    for (int i = 0; i < 15; i++) begin
      if (vecs[i].is_wr) axi_write(vecs[i].addr, vecs[i].data, vecs[i].strb, vecs[i].exp_resp);
      else               axi_read(vecs[i].addr, vecs[i].exp_rdata, vecs[i].exp_resp);
    end

    // W arrives three cycles before AW
    S_AXI_BREADY = 1'b1;
    S_AXI_WDATA = 32'h5A5A_A5A5; S_AXI_WSTRB = 4'hF; S_AXI_WVALID = 1'b1;
    chk("wfirst_wready_pre", S_AXI_WREADY, 1);
    tick();
    S_AXI_WVALID = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("wfirst_wready_held", S_AXI_WREADY, 0);
      chk("wfirst_no_bvalid", S_AXI_BVALID, 0);
      chk("wfirst_awready", S_AXI_AWREADY, 1);
      tick();
    end
    chk_regs("wfirst_no_commit");
    S_AXI_AWADDR = 32'h0000_000C; S_AXI_AWVALID = 1'b1;
    tick();
    S_AXI_AWVALID = 1'b0;
    chk("wfirst_b_not_yet", S_AXI_BVALID, 0);
    tick();
    chk("wfirst_bvalid", S_AXI_BVALID, 1);
    chk("wfirst_bresp", S_AXI_BRESP, 2'b00);
    model_write(32'h0000_000C, 32'h5A5A_A5A5, 4'hF);
    chk_regs("wfirst_regs");
    $display("WR addr=0x0000000c data=0x5a5aa5a5 strb=1111 bresp=%b (w before aw)", S_AXI_BRESP);
    tick();
    chk("wfirst_bvalid_drop", S_AXI_BVALID, 0);

    // BREADY held low for five cycles on a SLVERR response
    S_AXI_BREADY = 1'b0;
    S_AXI_AWADDR = 32'h0000_0044; S_AXI_AWVALID = 1'b1;
    S_AXI_WDATA = 32'h0F0F_0F0F; S_AXI_WSTRB = 4'hF; S_AXI_WVALID = 1'b1;
    tick();
    S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0;
    tick();
    for (int i = 0; i < 5; i++) begin
      chk("bstall_bvalid", S_AXI_BVALID, 1);
      chk("bstall_bresp", S_AXI_BRESP, 2'b10);
      chk("bstall_awready", S_AXI_AWREADY, 0);
      chk("bstall_wready", S_AXI_WREADY, 0);
      tick();
    end
    S_AXI_BREADY = 1'b1;
    tick();
    chk("bstall_release_bvalid", S_AXI_BVALID, 0);
    chk("bstall_release_awready", S_AXI_AWREADY, 1);
    chk("bstall_release_wready", S_AXI_WREADY, 1);
    chk_regs("bstall_regs");
    $display("WR addr=0x00000044 data=0x0f0f0f0f strb=1111 bresp=10 (bready stalled)");

    // RREADY held low for five cycles
    S_AXI_RREADY = 1'b0;
    S_AXI_ARADDR = 32'h0000_0008; S_AXI_ARVALID = 1'b1;
    tick();
    S_AXI_ARVALID = 1'b0;
    chk("rstall_rvalid_first", S_AXI_RVALID, 1);
    held_rdata = S_AXI_RDATA;
    chk("rstall_rdata_first", held_rdata, model[2]);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("rstall_rvalid", S_AXI_RVALID, 1);
      chk("rstall_rdata", S_AXI_RDATA, model[2]);
      chk("rstall_arready", S_AXI_ARREADY, 0);
    end
    S_AXI_RREADY = 1'b1;
    tick();
    chk("rstall_release_rvalid", S_AXI_RVALID, 0);
    chk("rstall_release_arready", S_AXI_ARREADY, 1);
    $display("RD addr=0x00000008 rdata=0x%08h rresp=00 (rready stalled)", held_rdata);

    // Read capture on the commit edge of a write to the same register
    S_AXI_AWADDR = 32'h0000_0004; S_AXI_AWVALID = 1'b1;
    S_AXI_WDATA = 32'h0BAD_F00D; S_AXI_WSTRB = 4'hF; S_AXI_WVALID = 1'b1;
    tick();
    S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0;
    S_AXI_ARADDR = 32'h0000_0004; S_AXI_ARVALID = 1'b1;
    tick();
    S_AXI_ARVALID = 1'b0;
    chk("collide_rvalid", S_AXI_RVALID, 1);
    chk("collide_rdata_old", S_AXI_RDATA, 32'h1234_5678);
    chk("collide_bvalid", S_AXI_BVALID, 1);
    model_write(32'h0000_0004, 32'h0BAD_F00D, 4'hF);
    chk_regs("collide_regs");
    $display("WR+RD addr=0x00000004 rdata=0x%08h (same edge)", S_AXI_RDATA);
    tick();
    chk("collide_bvalid_drop", S_AXI_BVALID, 0);
    chk("collide_rvalid_drop", S_AXI_RVALID, 0);

    // Reset while a W is held and a read response is pending
    S_AXI_WDATA = 32'hFFFF_FFFF; S_AXI_WSTRB = 4'hF; S_AXI_WVALID = 1'b1;
    tick();
    S_AXI_WVALID = 1'b0;
    S_AXI_RREADY = 1'b0;
    S_AXI_ARADDR = 32'h0000_0004; S_AXI_ARVALID = 1'b1;
    tick();
    S_AXI_ARVALID = 1'b0;
    chk("rstmid_pre_rvalid", S_AXI_RVALID, 1);
    ARESET = 1'b1;
    tick();
    ARESET = 1'b0;
    S_AXI_RREADY = 1'b1;
    for (int i = 0; i < NR; i++) model[i] = '0;
    chk("rstmid_awready", S_AXI_AWREADY, 0);
    chk("rstmid_wready", S_AXI_WREADY, 0);
    chk("rstmid_arready", S_AXI_ARREADY, 0);
    chk("rstmid_bvalid", S_AXI_BVALID, 0);
    chk("rstmid_rvalid", S_AXI_RVALID, 0);
    chk("rstmid_rdata", S_AXI_RDATA, 0);
    chk("rstmid_rresp", S_AXI_RRESP, 0);
    chk_regs("rstmid_regs");
    tick();
    chk("rstmid_release_awready", S_AXI_AWREADY, 1);
    chk("rstmid_release_wready", S_AXI_WREADY, 1);
    chk("rstmid_release_arready", S_AXI_ARREADY, 1);
    $display("RST mid-transaction");
    // The held W must be gone: an AW alone must not commit
    S_AXI_AWADDR = 32'h0000_0000; S_AXI_AWVALID = 1'b1;
    tick();
    S_AXI_AWVALID = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("rstmid_no_bvalid", S_AXI_BVALID, 0);
      chk("rstmid_no_rvalid", S_AXI_RVALID, 0);
      tick();
    end
    S_AXI_WDATA = 32'h0000_0077; S_AXI_WSTRB = 4'hF; S_AXI_WVALID = 1'b1;
    tick();
    S_AXI_WVALID = 1'b0;
    tick();
    chk("rstmid_after_bvalid", S_AXI_BVALID, 1);
    model_write(32'h0000_0000, 32'h0000_0077, 4'hF);
    chk_regs("rstmid_after_regs");
    $display("WR addr=0x00000000 data=0x00000077 strb=1111 bresp=%b (after reset)", S_AXI_BRESP);
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/axi_lite_slave_regs.md
Name: axi_lite_slave_regs

Overview:
AXI4-Lite slave exposing NUM_REGS 32-bit read/write registers. It sits directly downstream of the AXI4-Lite master and terminates its AW/W/B/AR/R channels. Register contents are exported in parallel to the design. Typical traffic is write 0x1234_5678 to 0x4, then read back 0x4.

Parameters:
ADDR_WIDTH, 32, width of AWADDR/ARADDR
NUM_REGS, 8, number of 32-bit registers (power of 2, >=2)

Ports:
ACLK  in  1  clock; all logic on rising edge
ARESET  in  1  synchronous reset, active-high
S_AXI_AWADDR  in  ADDR_WIDTH  write address
S_AXI_AWPROT  in  3  ignored
S_AXI_AWVALID  in  1  write address valid
S_AXI_AWREADY  out  1  write address ready
S_AXI_WDATA  in  32  write data
S_AXI_WSTRB  in  4  byte enables
S_AXI_WVALID  in  1  write data valid
S_AXI_WREADY  out  1  write data ready
S_AXI_BRESP  out  2  write response
S_AXI_BVALID  out  1  write response valid
S_AXI_BREADY  in  1  write response ready
S_AXI_ARADDR  in  ADDR_WIDTH  read address
S_AXI_ARPROT  in  3  ignored
S_AXI_ARVALID  in  1  read address valid
S_AXI_ARREADY  out  1  read address ready
S_AXI_RDATA  out  32  read data
S_AXI_RRESP  out  2  read response
S_AXI_RVALID  out  1  read data valid
S_AXI_RREADY  in  1  read data ready
REG_OUT  out  32*NUM_REGS  register contents; reg i at [32*i+31:32*i]

Behaviour:
- Reset (ARESET=1 at edge): all registers 0. AWREADY/WREADY/ARREADY/BVALID/RVALID=0. BRESP/RRESP=00. RDATA=0. Address/data holding flags cleared. Any in-flight transaction is dropped with no response. Readies rise the first cycle after reset deasserts.
- Decode: byte address; bits[1:0] ignored. Index = addr[2 +: log2(NUM_REGS)]. In range iff addr[ADDR_WIDTH-1:2] < NUM_REGS.
- Write path, with independent AW and W holding registers (aw_held, w_held):
  - AWREADY = !aw_held && !BVALID.
  - WREADY = !w_held && !BVALID.
  - AW handshake latches the address and sets aw_held. W handshake latches data/strb and sets w_held.
  - AW and W may arrive in either order or in the same cycle; neither waits on the other.
  - Commit occurs on the edge after both flags are set. Write latency is 1 cycle after the later handshake.
  - At commit: each byte with WSTRB[b]=1 is written. Both flags clear and BVALID=1.
  - BRESP=00 (OKAY) in range. Out of range: BRESP=10 (SLVERR) and no register changes.
  - BVALID/BRESP hold until BREADY. BVALID falls on the edge where BVALID&&BREADY. Readies reassert that same edge.
  - Maximum one outstanding write.
- Read path:
  - ARREADY = !RVALID.
  - On AR handshake, on the next edge: RVALID=1 and RDATA=reg[index], RRESP=00. Out of range: RDATA=0, RRESP=10.
  - RDATA/RRESP hold stable until RVALID&&RREADY; RVALID falls on that edge. Maximum one outstanding read.
- Read and write paths are fully independent and may run in the same cycle.
- If a write commit and read capture hit the same register on the same edge, the read returns the pre-write value.
- All outputs are registered. No combinational path from any input to any output.
- REG_OUT reflects a commit on the edge of the commit.

Decomposition:
- Shared package axi_lite_pkg:
  - RESP_OKAY=2'b00, RESP_SLVERR=2'b10
  - AXI_DATA_W=32, AXI_STRB_W=4
- Sub-module axi_lite_reg_bank: the NUM_REGS x 32 storage.
  - Inputs: byte-enable write port, one combinational read port.
  - Output: flattened REG_OUT.
- The slave handles handshakes and decode only.

Test Plan:
- AW(0x4) and W(0x1234_5678, strb 1111) in the same cycle, BREADY=1 -> BVALID 1 cycle later, BRESP=00, reg1=0x1234_5678. AR(0x4), RREADY=1 -> RVALID next cycle, RDATA=0x1234_5678, RRESP=00.
- W first, then AW three cycles later -> WREADY low while held, no commit until AW. BVALID 1 cycle after AW handshake.
- Write 0xAABB_CCDD to 0x8 with strb 0101 over prior 0x1122_3344 -> reg2=0x11BB_33DD.
- AW 0x40 (NUM_REGS=8) -> BRESP=10, REG_OUT unchanged. AR 0x40 -> RDATA=0, RRESP=10.
- BREADY held low 5 cycles -> BVALID/BRESP stable, AWREADY/WREADY low throughout. RREADY low similarly -> RDATA stable, ARREADY low.
- ARESET pulsed 1 cycle while a W is held and RVALID=1 -> all valids 0, all regs 0, no B/R issued. Readies high 1 cycle after release.
